// File: rtl/mod_final_sub_if.sv
// Bus bundle for the chunked final-subtraction unit.
// The master drives the request and the operands. The slave returns the
// reduced value and its status flags.
interface mod_final_sub_if #(
  parameter int T_WIDTH = 1028
);
  logic               start;
  logic [T_WIDTH-1:0] in_t;
  logic [T_WIDTH-2:0] in_m;
  logic [T_WIDTH-2:0] result;
  logic               done;
  logic               busy;
  logic               ovf;

  modport master (
    output start, in_t, in_m,
    input  result, done, busy, ovf
  );

  modport slave (
    input  start, in_t, in_m,
    output result, done, busy, ovf
  );
endinterface

// File: rtl/mod_final_sub.sv
// Final conditional subtraction of a modular reduction: result = t - m if
// t >= m, otherwise t. The subtraction runs one CHUNK_SIZE-bit slice per
// cycle (LSB first) with a registered borrow between slices, so no carry
// chain is longer than CHUNK_SIZE+1 bits. result, ovf and done are
// registered at the FIN->IDLE edge.
module mod_final_sub #(
  parameter int T_WIDTH    = 1028,
  parameter int CHUNK_SIZE = 257
) (
  input  logic           clk,
  input  logic           resetn,
  mod_final_sub_if.slave bus
);

  localparam int NCHUNK = T_WIDTH / CHUNK_SIZE;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SUB, FIN} state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             borrow_q, borrow_d;
  logic [T_WIDTH-2:0]               result_q, result_d;
  logic                             ovf_q, ovf_d;
  logic                             done_q, done_d;

  // Operand and difference storage, organised as slices so the active
  // slice can be indexed directly by the chunk counter.
  logic [NCHUNK-1:0][CHUNK_SIZE-1:0] t_q, m_q, d_q;

  logic [CHUNK_SIZE:0]              diff;
  logic [T_WIDTH-1:0]               sel;
  logic                             load, sub_en, fin, last_chunk;

  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SUB;
      SUB:     if (last_chunk) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode, slice subtraction and final selection.
  always_comb begin
    load     = (state_q == IDLE) && bus.start;
    sub_en   = (state_q == SUB);
    fin      = (state_q == FIN);
    bus.busy = (state_q != IDLE);

    // One slice with borrow-in; bit CHUNK_SIZE is the borrow-out.
    diff = {1'b0, t_q[cnt_q]} - {1'b0, m_q[cnt_q]}
           - {{CHUNK_SIZE{1'b0}}, borrow_q};

    // A final borrow means t < m, so t passes through unchanged.
    sel = borrow_q ? t_q : d_q;

    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    if (load) begin
      cnt_d    = '0;
      borrow_d = 1'b0;
    end else if (sub_en) begin
      cnt_d    = cnt_q + CNT_W'(1);
      borrow_d = diff[CHUNK_SIZE];
    end

    result_d = result_q;
    ovf_d    = ovf_q;
    if (fin) begin
      result_d = sel[T_WIDTH-2:0];
      ovf_d    = sel[T_WIDTH-1];
    end
    done_d = fin;
  end

  // Control and visible outputs; result/ovf hold until the next FIN.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Operand capture at acceptance and per-slice difference storage; no reset
  // needed since every bit is written before it is used.
  always_ff @(posedge clk) begin
    if (load) begin
      t_q <= bus.in_t;
      m_q <= {1'b0, bus.in_m};
    end
    if (sub_en) d_q[cnt_q] <= diff[CHUNK_SIZE-1:0];
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = done_q;

endmodule

// File: doc/mod_final_sub.md
MOD_FINAL_SUB -- requirements
Module: mod_final_sub

Interface
REQ-001 SHALL have parameter T_WIDTH, default 1028, width of the unreduced input.
REQ-002 SHALL have parameter CHUNK_SIZE, default 257, bits processed per cycle; T_WIDTH SHALL be a multiple of CHUNK_SIZE, giving NCHUNK = T_WIDTH/CHUNK_SIZE (default 4).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port in_t  input  T_WIDTH  unreduced value, e.g. the 1028-bit mpadder sum.
REQ-007 SHALL have port in_m  input  T_WIDTH-1  modulus, zero-extended internally to T_WIDTH.
REQ-008 SHALL have port result  output  T_WIDTH-1  reduced value.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port busy  output  1  high from start acceptance until done.
REQ-011 SHALL have port ovf  output  1  reduced value does not fit in T_WIDTH-1 bits.

Function
REQ-012 SHALL implement states IDLE, SUB, FIN; IDLE->SUB on start, SUB->FIN after NCHUNK chunk cycles, FIN->IDLE unconditionally.
REQ-013 SHALL, on accepting start, latch in_t and zero-extended in_m into internal registers, clear the chunk counter and clear the borrow register.
REQ-014 SHALL, in each SUB cycle, compute one CHUNK_SIZE-bit slice d = t - m - borrow, LSB slice first, store the slice, register its borrow-out and increment the counter.
REQ-015 SHALL never use a carry chain longer than CHUNK_SIZE+1 bits in one cycle.
REQ-016 SHALL select, in FIN, result = d[T_WIDTH-2:0] if the final borrow is 0 (t >= m), else result = t[T_WIDTH-2:0].
REQ-017 SHALL set ovf = 1 in FIN iff the selected value has bit T_WIDTH-1 set; otherwise ovf = 0.
REQ-018 SHALL assert done for exactly one cycle, NCHUNK+1 rising edges after the edge that sampled start (default 5).
REQ-019 SHALL hold result and ovf stable from done until the next start is accepted.
REQ-020 SHALL ignore start while busy; no relatch, no restart.
REQ-021 SHALL accept a start in the cycle immediately after done; back-to-back operations take NCHUNK+2 cycles each.
REQ-022 SHALL keep in_t/in_m changes after acceptance from affecting the current operation.
REQ-023 SHALL treat t == m as t >= m, giving result 0.

Reset
REQ-024 SHALL, when resetn is low at a rising edge, force state IDLE, result 0, done 0, busy 0, ovf 0, counter 0 and borrow 0, including mid-operation.
REQ-025 SHALL accept a start in the first cycle after resetn is high.

Verification
REQ-026 SHALL cover t=3000, m=1000 -> result 2000, ovf 0, done exactly 5 edges after start.
REQ-027 SHALL cover t=500, m=1000 -> result 500, ovf 0.
REQ-028 SHALL cover t=m=1027'h...full random value -> result 0.
REQ-029 SHALL cover t=2^257, m=1 -> result 2^257-1, i.e. 257 ones; checks borrow crossing chunk 0 -> 1.
REQ-030 SHALL cover t=2^1027+5, m=3 -> result 2, ovf 1; then start pulsed during busy -> ignored, single done.
REQ-031 SHALL cover resetn low in the 2nd SUB cycle -> next cycle busy 0, done 0, result 0; a following start with t=10, m=3 -> result 7.
